perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_counter.sv | 98 +++++++++
 rtl/perf_counter_bank.sv | 116 +++++++++++
 tb/tb_perf_counter_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: mode encodings,
// mode-bit positions and default parameter values.
package perf_pkg;

  // Counting mode held in cfg_mode[MODE_BIT]
  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } cnt_mode_e;

  // Bit positions inside the 2-bit cfg_mode field
  localparam int MODE_BIT   = 0;
  localparam int IRQ_EN_BIT = 1;

  // Default bank geometry
  localparam int DEF_NUM_CNT = 16;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_NUM_EVT = 16;

endpackage

// File: rtl/perf_counter.sv
// One performance counter: its own select/mode/enable registers, event
// selection with optional rising-edge qualification, and wrap/overflow.
module perf_counter
  import perf_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter int               NUM_EVT = DEF_NUM_EVT,
  parameter int               SEL_W   = $clog2(NUM_EVT),
  parameter logic [SEL_W-1:0] RST_SEL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] evtPrev_i,
  input  logic               freeze_i,
  input  logic               cfgWe_i,
  input  logic [SEL_W-1:0]   cfgSel_i,
  input  logic [1:0]         cfgMode_i,
  input  logic               cfgEn_i,
  input  logic               cntWe_i,
  input  logic [CNT_W-1:0]   cntWdata_i,
  input  logic               ovfClr_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               ovf_o,
  output logic               irqEn_o
);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [1:0]       mode_q, mode_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             selNow;
  logic             selPrev;
  logic             hit;

  // Pick the selected event bit and its previous value; unused select codes read as 0
  always_comb begin
    selNow  = 1'b0;
    selPrev = 1'b0;
    for (int e = 0; e < NUM_EVT; e++) begin
      if (sel_q == SEL_W'(e)) begin
        selNow  = evt_i[e];
        selPrev = evtPrev_i[e];
      end
    end
  end

  assign hit = en_q && !freeze_i &&
               ((mode_q[MODE_BIT] == 1'(MODE_EDGE)) ? (selNow && !selPrev) : selNow);

  // Next state: config writes, preload overriding increment, sticky overflow with set-wins
  always_comb begin
    sel_d  = sel_q;
    mode_d = mode_q;
    en_d   = en_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (cfgWe_i) begin
      sel_d  = cfgSel_i;
      mode_d = cfgMode_i;
      en_d   = cfgEn_i;
    end
    if (ovfClr_i) begin
      ovf_d = 1'b0;
    end
    if (cntWe_i) begin
      cnt_d = cntWdata_i;
    end else if (hit) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Counter state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= RST_SEL;
      mode_q <= 2'b00;
      en_q   <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      mode_q <= mode_d;
      en_q   <= en_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;
  assign irqEn_o = mode_q[IRQ_EN_BIT];

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT configurable event counters with registered readback,
// sticky overflow flags and a registered interrupt.
// Optional feature macro PERF_CNT_SNAPSHOT_EN adds snap/rd_src ports and a
// shadow copy of every counter selectable for readback.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int  NUM_CNT = DEF_NUM_CNT,
  parameter int  CNT_W   = DEF_CNT_W,
  parameter int  NUM_EVT = DEF_NUM_EVT,
  localparam int IDX_W   = $clog2(NUM_CNT),
  localparam int SEL_W   = $clog2(NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               freeze,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_en,
  input  logic               cnt_we,
  input  logic [IDX_W-1:0]   cnt_idx,
  input  logic [CNT_W-1:0]   cnt_wdata,
`ifdef PERF_CNT_SNAPSHOT_EN
  input  logic               snap,
  input  logic               rd_src,
`endif
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_CNT-1:0] ovf,
  input  logic [NUM_CNT-1:0] ovf_clr,
  output logic               irq
);

  logic [NUM_EVT-1:0] evtPrev_q;
  logic [CNT_W-1:0]   cntVal [NUM_CNT];
  logic [NUM_CNT-1:0] irqEn;
  logic [CNT_W-1:0]   rdData_q, rdData_d;
  logic               irq_q;

  // Previous value of every event line, shared by all edge-mode counters
  always_ff @(posedge clk) begin
    if (rst) evtPrev_q <= '0;
    else     evtPrev_q <= evt;
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter #(
      .CNT_W   (CNT_W),
      .NUM_EVT (NUM_EVT),
      .SEL_W   (SEL_W),
      .RST_SEL (SEL_W'(i % NUM_EVT))
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .evt_i      (evt),
      .evtPrev_i  (evtPrev_q),
      .freeze_i   (freeze),
      .cfgWe_i    (cfg_we && (cfg_idx == IDX_W'(i))),
      .cfgSel_i   (cfg_sel),
      .cfgMode_i  (cfg_mode),
      .cfgEn_i    (cfg_en),
      .cntWe_i    (cnt_we && (cnt_idx == IDX_W'(i))),
      .cntWdata_i (cnt_wdata),
      .ovfClr_i   (ovf_clr[i]),
      .cnt_o      (cntVal[i]),
      .ovf_o      (ovf[i]),
      .irqEn_o    (irqEn[i])
    );
  end

`ifdef PERF_CNT_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q [NUM_CNT];

  // Capture every live counter into the shadow bank on snap
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rst)       shadow_q[i] <= '0;
      else if (snap) shadow_q[i] <= cntVal[i];
    end
  end

  // Readback mux over live or shadow counters; out-of-range index reads 0
  always_comb begin
    rdData_d = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) rdData_d = rd_src ? shadow_q[i] : cntVal[i];
    end
  end
`else
  // Readback mux over live counters; out-of-range index reads 0
  always_comb begin
    rdData_d = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) rdData_d = cntVal[i];
    end
  end
`endif

  // Register readback data and the interrupt derived from current overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rdData_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      rdData_q <= rdData_d;
      irq_q    <= |(ovf & irqEn);
    end
  end

  assign rd_data = rdData_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank with NUM_CNT=3, CNT_W=8,
// NUM_EVT=8; snapshot steps are built only when PERF_CNT_SNAPSHOT_EN is defined.
module tb_perf_counter_bank;

  localparam int NUM_CNT = 3;
  localparam int CNT_W   = 8;
  localparam int NUM_EVT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       evt;
  logic             freeze;
  logic             cfg_we;
  logic [1:0]       cfg_idx;
  logic [2:0]       cfg_sel;
  logic [1:0]       cfg_mode;
  logic             cfg_en;
  logic             cnt_we;
  logic [1:0]       cnt_idx;
  logic [7:0]       cnt_wdata;
  logic [1:0]       rd_idx;
  logic [7:0]       rd_data;
  logic [2:0]       ovf;
  logic [2:0]       ovf_clr;
  logic             irq;
`ifdef PERF_CNT_SNAPSHOT_EN
  logic             snap;
  logic             rd_src;
`endif

  int compared   = 0;
  int mismatched = 0;

  perf_counter_bank #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W),
    .NUM_EVT (NUM_EVT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .evt       (evt),
    .freeze    (freeze),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_sel   (cfg_sel),
    .cfg_mode  (cfg_mode),
    .cfg_en    (cfg_en),
    .cnt_we    (cnt_we),
    .cnt_idx   (cnt_idx),
    .cnt_wdata (cnt_wdata),
`ifdef PERF_CNT_SNAPSHOT_EN
    .snap      (snap),
    .rd_src    (rd_src),
`endif
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Advance n clock edges, leaving the bench 1 time unit past the last edge
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Registered readback: apply index, one edge, then compare
  task automatic readCnt(input logic [1:0] idx, input logic [7:0] expv, input string tag);
    rd_idx = idx;
    applyStimulus(1);
    checkOutput(tag, 64'(rd_data), 64'(expv));
  endtask

  logic [5:0] edgePat;

  initial begin
    rst = 1'b1; evt = '0; freeze = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_mode = '0; cfg_en = 1'b0;
    cnt_we = 1'b0; cnt_idx = '0; cnt_wdata = '0; rd_idx = '0; ovf_clr = '0;
`ifdef PERF_CNT_SNAPSHOT_EN
    snap = 1'b0; rd_src = 1'b0;
`endif
    applyStimulus(1);

    // Reset must dominate config write, preload and events
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 3'd3; cfg_en = 1'b1;
    cnt_we = 1'b1; cnt_idx = 2'd0; cnt_wdata = 8'hAA; evt = 8'hFF;
    applyStimulus(1);
    checkOutput("rst_rd_data", 64'(rd_data), 64'h0);
    checkOutput("rst_ovf", 64'(ovf), 64'h0);
    checkOutput("rst_irq", 64'(irq), 64'h0);
    cfg_we = 1'b0; cnt_we = 1'b0; rst = 1'b0;
    applyStimulus(3);
    evt = '0;
    readCnt(2'd0, 8'd0, "rst_cnt0_disabled");
    readCnt(2'd1, 8'd0, "rst_cnt1_disabled");
    readCnt(2'd2, 8'd0, "rst_cnt2_disabled");
`ifdef PERF_CNT_SNAPSHOT_EN
    rd_src = 1'b1;
    readCnt(2'd0, 8'd0, "rst_shadow0");
    rd_src = 1'b0;
`endif

    // Level count of evt[3] on counter 0; counter 1 configured during first hit
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 3'd3; cfg_mode = 2'b00; cfg_en = 1'b1;
    applyStimulus(1);
    cfg_idx = 2'd1; evt = 8'h08;
    applyStimulus(1);
    cfg_we = 1'b0;
    applyStimulus(9);
    evt = '0;
    readCnt(2'd0, 8'd10, "level_cnt0");
    checkOutput("level_no_ovf", 64'(ovf), 64'h0);
    readCnt(2'd1, 8'd9, "cfg_takes_effect_next");

    // Edge mode on evt[5] with pattern 1,1,0,1,0,1
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_sel = 3'd5; cfg_mode = 2'b01; cfg_en = 1'b1;
    applyStimulus(1);
    cfg_we = 1'b0;
    edgePat = 6'b101011;
    for (int k = 0; k < 6; k++) begin
      evt = {2'b00, edgePat[k], 5'b00000};
      applyStimulus(1);
    end
    evt = '0;
    readCnt(2'd2, 8'd3, "edge_cnt2");

    // Wrap from FE with irq enabled on counter 0
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 3'd3; cfg_mode = 2'b10; cfg_en = 1'b1;
    cnt_we = 1'b1; cnt_idx = 2'd0; cnt_wdata = 8'hFE;
    applyStimulus(1);
    cfg_we = 1'b0; cnt_we = 1'b0; evt = 8'h08;
    applyStimulus(2);
    checkOutput("wrap_ovf_set", 64'(ovf), 64'h1);
    checkOutput("irq_lag", 64'(irq), 64'h0);
    applyStimulus(1);
    evt = '0;
    checkOutput("irq_set", 64'(irq), 64'h1);
    readCnt(2'd0, 8'd1, "wrap_cnt0");
    readCnt(2'd1, 8'd12, "cnt1_no_wrap");
    ovf_clr = 3'b001;
    applyStimulus(1);
    ovf_clr = '0;
    checkOutput("ovf_clr", 64'(ovf), 64'h0);
    applyStimulus(1);
    checkOutput("irq_clr", 64'(irq), 64'h0);
    cnt_we = 1'b1; cnt_idx = 2'd1; cnt_wdata = 8'hFF;
    applyStimulus(1);
    cnt_we = 1'b0; evt = 8'h08;
    applyStimulus(1);
    evt = '0;
    checkOutput("ovf_cnt1", 64'(ovf), 64'h2);
    applyStimulus(1);
    checkOutput("irq_masked", 64'(irq), 64'h0);

    // Preload overrides same-cycle increment and never sets overflow
    cnt_we = 1'b1; cnt_idx = 2'd0; cnt_wdata = 8'hFF;
    applyStimulus(1);
    cnt_wdata = 8'h55; evt = 8'h08;
    applyStimulus(1);
    cnt_we = 1'b0; evt = '0;
    readCnt(2'd0, 8'h55, "load_overrides_inc");
    checkOutput("load_no_ovf", 64'(ovf), 64'h2);

    // Same-cycle clear and overflow: set wins
    cnt_we = 1'b1; cnt_idx = 2'd1; cnt_wdata = 8'hFF;
    applyStimulus(1);
    cnt_we = 1'b0; evt = 8'h08; ovf_clr = 3'b010;
    applyStimulus(1);
    evt = '0; ovf_clr = '0;
    checkOutput("clr_vs_ovf_set_wins", 64'(ovf), 64'h2);
    readCnt(2'd1, 8'd0, "wrap_cnt1");

    // Freeze inhibits counting
    freeze = 1'b1; evt = 8'h08;
    applyStimulus(5);
    freeze = 1'b0; evt = '0;
    readCnt(2'd0, 8'h56, "freeze_hold");

    // Out-of-range config/preload index ignored
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_sel = 3'd0; cfg_mode = 2'b00; cfg_en = 1'b0;
    cnt_we = 1'b1; cnt_idx = 2'd3; cnt_wdata = 8'hAA;
    applyStimulus(1);
    cfg_we = 1'b0; cnt_we = 1'b0; evt = 8'h08;
    applyStimulus(2);
    evt = '0;
    readCnt(2'd0, 8'h58, "oob_cfg_cnt0");
    readCnt(2'd1, 8'd2, "oob_cfg_cnt1");
    readCnt(2'd2, 8'd3, "oob_cfg_cnt2");
    readCnt(2'd3, 8'd0, "oob_rd_zero");

`ifdef PERF_CNT_SNAPSHOT_EN
    // Snapshot holds 7 while live counter advances to 11
    cnt_we = 1'b1; cnt_idx = 2'd0; cnt_wdata = 8'd7;
    applyStimulus(1);
    cnt_we = 1'b0; snap = 1'b1;
    applyStimulus(1);
    snap = 1'b0; evt = 8'h08;
    applyStimulus(4);
    evt = '0;
    rd_src = 1'b1;
    readCnt(2'd0, 8'd7, "snap_shadow");
    rd_src = 1'b0;
    readCnt(2'd0, 8'd11, "snap_live");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
